// File: rtl/control_unit.sv
// control_unit: microcoded T-state sequencer for the 8-bit computer; decodes opcode+step into the control word.
// Optional feature: define FLAGS_EN for FI on ADD/SUB and conditional jumps JC/JZ.
`default_nettype none

module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       HLT,
  output logic       MI,
  output logic       WE,
  output logic       RO,
  output logic       II,
  output logic       IO,
  output logic       AI,
  output logic       AO,
  output logic       BI,
  output logic       EO,
  output logic       SU,
  output logic       OI,
  output logic       CE,
  output logic       CO,
  output logic       J,
  output logic       FI,
  output logic [2:0] step
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  localparam logic [15:0] CW_HLT = 16'h8000;
  localparam logic [15:0] CW_MI  = 16'h4000;
  localparam logic [15:0] CW_WE  = 16'h2000;
  localparam logic [15:0] CW_RO  = 16'h1000;
  localparam logic [15:0] CW_II  = 16'h0800;
  localparam logic [15:0] CW_IO  = 16'h0400;
  localparam logic [15:0] CW_AI  = 16'h0200;
  localparam logic [15:0] CW_AO  = 16'h0100;
  localparam logic [15:0] CW_BI  = 16'h0080;
  localparam logic [15:0] CW_EO  = 16'h0040;
  localparam logic [15:0] CW_SU  = 16'h0020;
  localparam logic [15:0] CW_OI  = 16'h0010;
  localparam logic [15:0] CW_CE  = 16'h0008;
  localparam logic [15:0] CW_CO  = 16'h0004;
  localparam logic [15:0] CW_J   = 16'h0002;
  localparam logic [15:0] CW_FI  = 16'h0001;

  step_t       step_q, step_d;
  logic        halted_q, halted_d;
  logic [15:0] cw;
  logic        last;

`ifdef FLAGS_EN
  localparam logic [15:0] CW_ALU_END = CW_EO | CW_AI | CW_FI;
  localparam bit          COND_JUMPS = 1'b1;
`else
  localparam logic [15:0] CW_ALU_END = CW_EO | CW_AI;
  localparam bit          COND_JUMPS = 1'b0;
  logic unused_flags;
  assign unused_flags = carry_flag ^ zero_flag;
`endif

  // Opcodes with no execute microsteps finish at T1; opcode is only needed here for the next-state choice.
  function automatic logic no_execute(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hE, 4'hF: no_execute = 1'b0;
      4'h7, 4'h8:                                     no_execute = !COND_JUMPS;
      default:                                        no_execute = 1'b1;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    cw       = '0;
    last     = 1'b0;
    step_d   = step_q;
    halted_d = halted_q;
    if (halted_q) begin
      cw = CW_HLT;
    end else begin
      case (step_q)
        T0: cw = CW_CO | CW_MI;
        T1: begin
          cw   = CW_RO | CW_II | CW_CE;
          last = no_execute(opcode);
        end
        default: begin
          case (opcode)
            4'h1: begin
              cw   = (step_q == T2) ? (CW_IO | CW_MI) : (CW_RO | CW_AI);
              last = (step_q == T3);
            end
            4'h2, 4'h3: begin
              case (step_q)
                T2:      cw = CW_IO | CW_MI;
                T3:      cw = CW_RO | CW_BI;
                default: cw = CW_ALU_END | ((opcode == 4'h3) ? CW_SU : 16'h0000);
              endcase
              last = (step_q == T4);
            end
            4'h4: begin
              cw   = (step_q == T2) ? (CW_IO | CW_MI) : (CW_AO | CW_WE);
              last = (step_q == T3);
            end
            4'h5: begin cw = CW_IO | CW_AI; last = 1'b1; end
            4'h6: begin cw = CW_IO | CW_J;  last = 1'b1; end
`ifdef FLAGS_EN
            4'h7: begin cw = carry_flag ? (CW_IO | CW_J) : 16'h0000; last = 1'b1; end
            4'h8: begin cw = zero_flag  ? (CW_IO | CW_J) : 16'h0000; last = 1'b1; end
`endif
            4'hE: begin cw = CW_AO | CW_OI; last = 1'b1; end
            4'hF: begin cw = CW_HLT;        last = 1'b1; end
            default: last = 1'b1;
          endcase
        end
      endcase

      if (step_q == T2 && opcode == 4'hF) begin
        halted_d = 1'b1;
      end else if (last) begin
        step_d = T0;
      end else begin
        step_d = step_t'(step_q + 3'd1);
      end
    end
  end

  // Reset masks every control line so nothing is loaded or written while rst is held.
  assign {HLT, MI, WE, RO, II, IO, AI, AO, BI, EO, SU, OI, CE, CO, J, FI} = rst ? 16'h0000 : cw;
  assign step = step_q;

endmodule

`default_nettype wire

// File: tb/tb_control_unit.sv
// tb_control_unit: directed sequence with an expected-control-word scoreboard for control_unit.
`default_nettype none

module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       carry_flag, zero_flag;
  logic       HLT, MI, WE, RO, II, IO, AI, AO, BI, EO, SU, OI, CE, CO, J, FI;
  logic [2:0] step;

  int n_cmp = 0;
  int n_err = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .HLT(HLT), .MI(MI), .WE(WE), .RO(RO), .II(II), .IO(IO), .AI(AI), .AO(AO), .BI(BI),
    .EO(EO), .SU(SU), .OI(OI), .CE(CE), .CO(CO), .J(J), .FI(FI), .step(step)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] B_HLT = 16'h8000, B_MI = 16'h4000, B_WE = 16'h2000, B_RO = 16'h1000;
  localparam logic [15:0] B_II  = 16'h0800, B_IO = 16'h0400, B_AI = 16'h0200, B_AO = 16'h0100;
  localparam logic [15:0] B_BI  = 16'h0080, B_EO = 16'h0040, B_SU = 16'h0020, B_OI = 16'h0010;
  localparam logic [15:0] B_CE  = 16'h0008, B_CO = 16'h0004, B_J  = 16'h0002, B_FI = 16'h0001;

  typedef struct {
    logic [18:0] word;   // {step, control word}
    string       tag;
  } exp_t;

  exp_t sb[$];

  function automatic logic [15:0] ctl_now();
    return {HLT, MI, WE, RO, II, IO, AI, AO, BI, EO, SU, OI, CE, CO, J, FI};
  endfunction

  // Reference microcode: list of control words for one instruction, T0 first.
  function automatic int ref_len(input logic [3:0] op, input logic c, input logic z);
    case (op)
      4'h1, 4'h4:             return 4;
      4'h2, 4'h3:             return 5;
      4'h5, 4'h6, 4'hE, 4'hF: return 3;
`ifdef FLAGS_EN
      4'h7, 4'h8:             return 3;
`endif
      default:                return 2;
    endcase
  endfunction

  function automatic logic [15:0] ref_ctl(input logic [3:0] op, input int t, input logic c, input logic z);
    logic [15:0] fi;
`ifdef FLAGS_EN
    fi = B_FI;
`else
    fi = 16'h0000;
`endif
    if (t == 0) return B_CO | B_MI;
    if (t == 1) return B_RO | B_II | B_CE;
    case (op)
      4'h1: return (t == 2) ? (B_IO | B_MI) : (B_RO | B_AI);
      4'h2: return (t == 2) ? (B_IO | B_MI) : (t == 3) ? (B_RO | B_BI) : (B_EO | B_AI | fi);
      4'h3: return (t == 2) ? (B_IO | B_MI) : (t == 3) ? (B_RO | B_BI) : (B_EO | B_AI | B_SU | fi);
      4'h4: return (t == 2) ? (B_IO | B_MI) : (B_AO | B_WE);
      4'h5: return B_IO | B_AI;
      4'h6: return B_IO | B_J;
`ifdef FLAGS_EN
      4'h7: return c ? (B_IO | B_J) : 16'h0000;
      4'h8: return z ? (B_IO | B_J) : 16'h0000;
`endif
      4'hE: return B_AO | B_OI;
      4'hF: return B_HLT;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check_pop();
    exp_t e;
    logic [18:0] obs;
    obs = {step, ctl_now()};
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %h required an expected entry", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.word) else begin
      n_err++;
      $error("FAIL %s: observed step/ctl %h required %h", e.tag, obs, e.word);
    end
  endtask

  // Called mid-cycle while the DUT sits in T0; leaves the bench mid-cycle at the following T0.
  task automatic run_instr(input logic [3:0] op, input logic c, input logic z);
    int n;
    opcode = op; carry_flag = c; zero_flag = z;
    n = ref_len(op, c, z);
    for (int t = 0; t < n; t++)
      sb.push_back('{word: {3'(t), ref_ctl(op, t, c, z)}, tag: $sformatf("op%h_T%0d", op, t)});
    for (int t = 0; t < n; t++) begin
      check_pop();
      @(negedge clk);
    end
  endtask

  task automatic check_reset_quiet(input string tag);
    n_cmp++;
    assert (ctl_now() === 16'h0000) else begin
      n_err++;
      $error("FAIL %s: observed ctl %h required 0000", tag, ctl_now());
    end
  endtask

  // Hold rst for two edges, then release mid-cycle so the current cycle becomes T0.
  task automatic do_reset();
    rst = 1'b1;
    #1 check_reset_quiet("reset_ctl_a");
    @(negedge clk);
    check_reset_quiet("reset_ctl_b");
    @(negedge clk);
    check_reset_quiet("reset_ctl_c");
    rst = 1'b0;
    #1;
  endtask

  // At most one bus driver in any cycle.
  always @(negedge clk) begin
    n_cmp++;
    assert ($countones({RO, IO, AO, EO, CO}) <= 1) else begin
      n_err++;
      $error("FAIL bus_contention: observed drivers %b required at most one", {RO, IO, AO, EO, CO});
    end
  end

  initial begin
    rst = 1'b1; opcode = 4'b0010; carry_flag = 1'b0; zero_flag = 1'b0;
    @(negedge clk);
    do_reset();

    // Every opcode except HLT, flags randomised where they should be irrelevant
    for (int op = 0; op < 15; op++)
      run_instr(4'(op), 1'($urandom_range(1)), 1'($urandom_range(1)));

    // Conditional-jump / NOP opcodes with both flag values
    run_instr(4'h7, 1'b1, 1'b0);
    run_instr(4'h7, 1'b0, 1'b1);
    run_instr(4'h8, 1'b0, 1'b1);
    run_instr(4'h8, 1'b1, 1'b0);

    // HLT: three cycles, then frozen at step 2 with only HLT asserted
    run_instr(4'hF, 1'b0, 1'b0);
    opcode = 4'h0;
    for (int i = 0; i < 4; i++)
      sb.push_back('{word: {3'd2, B_HLT}, tag: $sformatf("halted_%0d", i)});
    for (int i = 0; i < 4; i++) begin
      check_pop();
      @(negedge clk);
    end
    do_reset();

    // Reset during ADD T3: abandon the instruction, restart at T0
    opcode = 4'h2;
    for (int t = 0; t < 4; t++)
      sb.push_back('{word: {3'(t), ref_ctl(4'h2, t, 1'b0, 1'b0)}, tag: $sformatf("midrst_T%0d", t)});
    for (int t = 0; t < 4; t++) begin
      check_pop();
      if (t < 3) @(negedge clk);
    end
    do_reset();
    run_instr(4'h0, 1'b0, 1'b0);
    run_instr(4'h2, 1'b1, 1'b1);
    run_instr(4'hE, 1'b0, 1'b0);

    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain: observed %0d left required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
